// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer: word-aligned memory port, read-modify-write for sub-word stores.
// Optional MEMSEQ_ALIGN_EXC_EN: misaligned/illegal requests respond with rsp_err instead of being aligned.
module mem_access_seq #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rword_q, rword_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d, signed_q, signed_d;
    logic [1:0]  size_n;
    logic [31:0] addr_n;
    logic        bad;
`ifdef MEMSEQ_ALIGN_EXC_EN
    logic        err_q, err_d;
`endif

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] a, input logic sgn);
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> {a, 3'b000};
        case (sz)
            2'b10:   r = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   r = {{16{sgn & sh[15]}}, sh[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] a);
        logic [4:0]  s;
        logic [31:0] m;
        s = {a, 3'b000};
        m = (sz == 2'b10) ? (32'h0000_00FF << s) : (32'h0000_FFFF << s);
        return (w & ~m) | ((wd << s) & m);
    endfunction

    // Request normalisation: either flag the access as bad or silently align it.
    always_comb begin
        size_n = req_size;
        addr_n = req_addr;
`ifdef MEMSEQ_ALIGN_EXC_EN
        bad = (req_size == 2'b11) ||
              (req_size == 2'b00 && req_addr[1:0] != 2'b00) ||
              (req_size == 2'b01 && req_addr[0]);
`else
        bad = 1'b0;
        if (req_size == 2'b11) size_n = 2'b00;
        if (size_n == 2'b01) addr_n[0] = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rword_d  = rword_q;
        size_d   = size_q;
        write_d  = write_q;
        signed_d = signed_q;
`ifdef MEMSEQ_ALIGN_EXC_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = addr_n;
                    wdata_d  = req_wdata;
                    size_d   = size_n;
                    write_d  = req_write;
                    signed_d = req_signed;
                    cnt_d    = 3'(MEM_LATENCY);
`ifdef MEMSEQ_ALIGN_EXC_EN
                    err_d    = bad;
`endif
                    if (bad)                                 state_d = RESP;
                    else if (req_write && size_n == 2'b00)   state_d = WRITE;
                    else                                     state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    rword_d = mem_rdata;
                    if (write_q) begin
                        state_d = WRITE;
                    end else begin
                        rdata_d = extract(mem_rdata, size_q, addr_q[1:0], signed_q);
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        rword_q  <= rword_d;
        size_q   <= size_d;
        write_q  <= write_d;
        signed_q <= signed_d;
`ifdef MEMSEQ_ALIGN_EXC_EN
        err_q    <= err_d;
`endif
    end

    // Outputs are decoded from state; reset gates the handshakes and the write strobe.
    always_comb begin
        req_ready = (state_q == IDLE) && !reset;
        rsp_valid = (state_q == RESP) && !reset;
        rsp_rdata = rdata_q;
        mem_wr    = (state_q == WRITE) && !reset;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (state_q == RD_WAIT || state_q == WRITE) mem_addr = {addr_q[31:2], 2'b00};
        if (state_q == WRITE)
            mem_wdata = (size_q == 2'b00) ? wdata_q : merge(rword_q, wdata_q, size_q, addr_q[1:0]);
`ifdef MEMSEQ_ALIGN_EXC_EN
        rsp_err = rsp_valid && err_q;
`else
        rsp_err = 1'b0;
`endif
    end
endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: scoreboard queues for responses and memory writes.
module tb_mem_access_seq;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_seq #(.MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on the clock edge; preload port for the bench.
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_data = 32'd0;
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_wr)      mem[mem_addr[9:2]] <= mem_wdata;
        else if (pre_we) mem[pre_idx] <= pre_data;
    end

    typedef struct { int cyc; logic upd; logic [31:0] rd; logic err; } rsp_t;
    typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
    rsp_t rq[$];
    wr_t  wq[$];
    logic [31:0] model_rd = 32'd0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else begin
                rsp_t e;
                e = rq.pop_front();
                if (e.upd) model_rd = e.rd;
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_rdata", rsp_rdata, model_rd);
            end
        end
        if (mem_wr) begin
            if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_cycle", cyc, w.cyc);
                chk("wr_addr", mem_addr, w.addr);
                chk("wr_data", mem_wdata, w.data);
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_idx = a[9:2]; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Drives a request and waits for its accept; req_valid is left high on return.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit exp_rsp, input int lat, input logic upd,
                         input logic [31:0] rd, input logic err,
                         input bit exp_wr, input int wr_off, input logic [31:0] wdat,
                         output int t_acc);
        bit done;
        req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        done = 1'b0;
        t_acc = -1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                rsp_t r;
                wr_t  w;
                t_acc = cyc;
                if (exp_rsp) begin
                    r.cyc = t_acc + lat; r.upd = upd; r.rd = rd; r.err = err;
                    rq.push_back(r);
                end
                if (exp_wr) begin
                    w.cyc = t_acc + wr_off; w.addr = {a[31:2], 2'b00}; w.data = wdat;
                    wq.push_back(w);
                end
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end
    endtask

    task automatic load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] rd);
        int t;
        issue(1'b0, sz, sg, a, 32'd0, 1'b1, LAT + 1, 1'b1, rd, 1'b0, 1'b0, 0, 32'd0, t);
        req_valid = 1'b0;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] wdat);
        int t;
        if (sz == 2'b00)
            issue(1'b1, sz, 1'b0, a, wd, 1'b1, 2, 1'b0, 32'd0, 1'b0, 1'b1, 1, wdat, t);
        else
            issue(1'b1, sz, 1'b0, a, wd, 1'b1, LAT + 2, 1'b0, 32'd0, 1'b0, 1'b1, LAT + 1, wdat, t);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (rq.size() != 0 || wq.size() != 0); i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int t1, t2;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Word load
        preload(32'h100, 32'h1122_3344);
        load(2'b00, 1'b0, 32'h100, 32'h1122_3344);
        drain();

        // Sub-word loads with extension
        preload(32'h100, 32'h80FF_7F01);
        load(2'b10, 1'b1, 32'h102, 32'hFFFF_FFFF);
        load(2'b10, 1'b0, 32'h102, 32'h0000_00FF);
        load(2'b01, 1'b1, 32'h102, 32'hFFFF_80FF);
        load(2'b01, 1'b0, 32'h100, 32'h0000_7F01);
        load(2'b10, 1'b1, 32'h103, 32'hFFFF_FF80);
        load(2'b10, 1'b0, 32'h103, 32'h0000_0080);
        load(2'b10, 1'b1, 32'h100, 32'h0000_0001);
        load(2'b00, 1'b1, 32'h100, 32'h80FF_7F01);
        drain();

        // Read-modify-write stores
        preload(32'h100, 32'h1122_3344);
        store(2'b10, 32'h101, 32'h0000_00AB, 32'h1122_AB44);
        store(2'b01, 32'h102, 32'h0000_BEEF, 32'hBEEF_AB44);
        store(2'b10, 32'h103, 32'hFFFF_FF77, 32'h77EF_AB44);
        load(2'b00, 1'b0, 32'h100, 32'h77EF_AB44);
        drain();

        // Misaligned and illegal requests
`ifdef MEMSEQ_ALIGN_EXC_EN
        issue(1'b0, 2'b00, 1'b0, 32'h102, 32'd0, 1'b1, 1, 1'b0, 32'd0, 1'b1, 1'b0, 0, 32'd0, t1);
        req_valid = 1'b0;
        issue(1'b0, 2'b11, 1'b0, 32'h100, 32'd0, 1'b1, 1, 1'b0, 32'd0, 1'b1, 1'b0, 0, 32'd0, t1);
        req_valid = 1'b0;
        issue(1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, 1'b1, 1, 1'b0, 32'd0, 1'b1, 1'b0, 0, 32'd0, t1);
        req_valid = 1'b0;
`else
        load(2'b00, 1'b0, 32'h102, 32'h77EF_AB44);
        load(2'b11, 1'b0, 32'h100, 32'h77EF_AB44);
        load(2'b01, 1'b0, 32'h103, 32'h0000_77EF);
`endif
        load(2'b00, 1'b0, 32'h100, 32'h77EF_AB44);
        drain();

        // Reset during RD_WAIT of a halfword store
        issue(1'b1, 2'b01, 1'b0, 32'h100, 32'h5555, 1'b0, 0, 1'b0, 32'd0, 1'b0, 1'b0, 0, 32'd0, t1);
        req_valid = 1'b0;
        reset = 1'b1;
        model_rd = 32'd0;
        @(negedge clk);
        chk("rdwait_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rdwait_rst_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("after_rst_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        load(2'b00, 1'b0, 32'h100, 32'h77EF_AB44);
        drain();

        // Reset during WRITE of a word store
        issue(1'b1, 2'b00, 1'b0, 32'h100, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 32'd0, 1'b0, 1'b0, 0, 32'd0, t1);
        req_valid = 1'b0;
        reset = 1'b1;
        model_rd = 32'd0;
        @(negedge clk);
        chk("write_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        load(2'b00, 1'b0, 32'h100, 32'h77EF_AB44);
        drain();

        // Back-to-back word stores with req_valid held high
        issue(1'b1, 2'b00, 1'b0, 32'h200, 32'hDEAD_BEEF, 1'b1, 2, 1'b0, 32'd0, 1'b0, 1'b1, 1,
              32'hDEAD_BEEF, t1);
        issue(1'b1, 2'b00, 1'b0, 32'h204, 32'h0102_0304, 1'b1, 2, 1'b0, 32'd0, 1'b0, 1'b1, 1,
              32'h0102_0304, t2);
        req_valid = 1'b0;
        chk("b2b_accept_gap", t2 - t1, 32'd3);
        load(2'b00, 1'b0, 32'h200, 32'hDEAD_BEEF);
        load(2'b00, 1'b0, 32'h204, 32'h0102_0304);
        drain();

        repeat (4) @(posedge clk);
        #1;
        chk("rsp_queue_empty", rq.size(), 32'd0);
        chk("wr_queue_empty", wq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
